// File: rtl/reg_result_scheduler.sv
// Issue scheduler for one register file. Pending functional-unit results sit
// in a delay-indexed shift pipeline that drives the result bus from slot 0.
module reg_result_scheduler #(
  parameter int NREG   = 8,
  parameter int REGW   = 3,
  parameter int MAXLAT = 14,
  parameter int SRCW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [REGW-1:0] i_dest,
  input  logic            i_dest_en,
  input  logic [3:0]      i_delay,
  input  logic [SRCW-1:0] i_src,
  input  logic [NREG-1:0] i_rd_mask,
  input  logic            i_ext_conflict,
  input  logic            i_issue_vld,
  input  logic            i_kill,
  output logic            o_issue,
  output logic            o_result_en,
  output logic [SRCW-1:0] o_result_src,
  output logic [REGW-1:0] o_result_dest,
  output logic [NREG-1:0] o_res_mask,
  output logic            o_r0_busy,
  output logic            o_err
);

  localparam logic [3:0] MAXLAT_4 = 4'(MAXLAT);

  logic            r_en   [MAXLAT];
  logic [SRCW-1:0] r_src  [MAXLAT];
  logic [NREG-1:0] r_dest [MAXLAT];
  logic            r_err;

  logic [NREG-1:0] w_slot_mask [MAXLAT];
  logic [NREG-1:0] w_res_mask;
  logic [NREG-1:0] w_dest_oh;
  logic [REGW-1:0] w_enc;
  logic            w_delay_ok;
  logic            w_wp;
  logic            w_hz;
  logic            w_issue;
  logic            w_load;
  logic            w_err_evt;

  genvar gi;
  generate
    for (gi = 0; gi < MAXLAT; gi++) begin : g_slot_mask
      assign w_slot_mask[gi] = r_en[gi] ? r_dest[gi] : '0;
    end
  endgenerate

  always_comb begin
    w_res_mask = '0;
    for (int k = 0; k < MAXLAT; k++) begin
      w_res_mask = w_res_mask | w_slot_mask[k];
    end
  end

  assign w_dest_oh  = NREG'(1) << i_dest;
  assign w_delay_ok = (i_delay != 4'd0) && (i_delay <= MAXLAT_4);

  // The entry that would shift into the target slot on this edge collides
  // with the new load; at the maximum delay nothing can be above it.
  always_comb begin
    w_wp = 1'b0;
    for (int k = 1; k < MAXLAT; k++) begin
      if (i_delay == 4'(k)) w_wp = r_en[k];
    end
  end

  assign w_hz      = |((i_rd_mask | (i_dest_en ? w_dest_oh : '0)) & w_res_mask);
  assign w_issue   = i_req & ~i_kill & ~i_ext_conflict & ~w_hz &
                     (~i_dest_en | (w_delay_ok & ~w_wp));
  assign w_load    = i_req & i_dest_en & i_issue_vld & w_issue & ~i_kill;
  assign w_err_evt = (i_issue_vld & i_req & ~w_issue & ~i_kill) |
                     (i_issue_vld & i_req & i_dest_en & ~w_delay_ok);

  always_ff @(posedge clk) begin
    if (rst || i_kill) begin
      for (int k = 0; k < MAXLAT; k++) begin
        r_en[k]   <= 1'b0;
        r_src[k]  <= '0;
        r_dest[k] <= '0;
      end
    end else begin
      for (int k = 0; k < MAXLAT - 1; k++) begin
        r_en[k]   <= r_en[k+1];
        r_src[k]  <= r_src[k+1];
        r_dest[k] <= r_dest[k+1];
      end
      r_en[MAXLAT-1]   <= 1'b0;
      r_src[MAXLAT-1]  <= '0;
      r_dest[MAXLAT-1] <= '0;
      // A load replaces whatever would have shifted into its slot.
      for (int k = 0; k < MAXLAT; k++) begin
        if (w_load && (i_delay == 4'(k + 1))) begin
          r_en[k]   <= 1'b1;
          r_src[k]  <= i_src;
          r_dest[k] <= w_dest_oh;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
    end
  end

  // Lowest set bit wins so a corrupt multi-hot field still yields one index.
  always_comb begin
    w_enc = '0;
    for (int k = NREG - 1; k >= 0; k--) begin
      if (r_en[0] && r_dest[0][k]) w_enc = REGW'(k);
    end
  end

  assign o_issue       = w_issue;
  assign o_result_en   = r_en[0];
  assign o_result_src  = r_src[0];
  assign o_result_dest = w_enc;
  assign o_res_mask    = w_res_mask;
  assign o_r0_busy     = w_res_mask[0];
  assign o_err         = r_err;

endmodule

// File: tb/tb_reg_result_scheduler.sv
// Bench for reg_result_scheduler: directed and random stimulus against a
// model that tracks pending results by their delivery cycle.
module tb_reg_result_scheduler;

  localparam int NREG = 8, REGW = 3, MAXLAT = 14, SRCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            i_req, i_dest_en, i_ext_conflict, i_issue_vld, i_kill;
  logic [REGW-1:0] i_dest;
  logic [3:0]      i_delay;
  logic [SRCW-1:0] i_src;
  logic [NREG-1:0] i_rd_mask;
  logic            o_issue, o_result_en, o_r0_busy, o_err;
  logic [SRCW-1:0] o_result_src;
  logic [REGW-1:0] o_result_dest;
  logic [NREG-1:0] o_res_mask;

  reg_result_scheduler #(.NREG(NREG), .REGW(REGW), .MAXLAT(MAXLAT), .SRCW(SRCW)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_dest(i_dest), .i_dest_en(i_dest_en),
    .i_delay(i_delay), .i_src(i_src), .i_rd_mask(i_rd_mask),
    .i_ext_conflict(i_ext_conflict), .i_issue_vld(i_issue_vld), .i_kill(i_kill),
    .o_issue(o_issue), .o_result_en(o_result_en), .o_result_src(o_result_src),
    .o_result_dest(o_result_dest), .o_res_mask(o_res_mask), .o_r0_busy(o_r0_busy),
    .o_err(o_err));

  // Second instance with a wider file and source code.
  logic        b_rst, b_req, b_dest_en, b_vld;
  logic [3:0]  b_dest, b_delay, b_rdest;
  logic [4:0]  b_src, b_rsrc;
  logic [15:0] b_rd_mask, b_mask;
  logic        b_issue, b_ren, b_r0, b_err;

  reg_result_scheduler #(.NREG(16), .REGW(4), .MAXLAT(14), .SRCW(5)) dut16 (
    .clk(clk), .rst(b_rst), .i_req(b_req), .i_dest(b_dest), .i_dest_en(b_dest_en),
    .i_delay(b_delay), .i_src(b_src), .i_rd_mask(b_rd_mask),
    .i_ext_conflict(1'b0), .i_issue_vld(b_vld), .i_kill(1'b0),
    .o_issue(b_issue), .o_result_en(b_ren), .o_result_src(b_rsrc),
    .o_result_dest(b_rdest), .o_res_mask(b_mask), .o_r0_busy(b_r0), .o_err(b_err));

  int checks = 0, errors = 0;

  typedef struct {
    int due;
    int src;
    int dest;
  } pend_t;

  pend_t pq[$];
  int    now = 0;
  bit    err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_mask();
    int m = 0;
    foreach (pq[j]) m |= (1 << pq[j].dest);
    return m;
  endfunction

  function automatic bit m_collide(input int d);
    foreach (pq[j]) if (pq[j].due == now + d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_issue(input bit req, input int dest, input bit den, input int d,
                                 input int rd, input bit ext, input bit kill);
    bit hz, dok, wp;
    hz  = ((rd | (den ? (1 << dest) : 0)) & m_mask()) != 0;
    dok = (d >= 1) && (d <= MAXLAT);
    wp  = (d < MAXLAT) && m_collide(d);
    return req && !kill && !ext && !hz && (!den || (dok && !wp));
  endfunction

  // One clock cycle: drive, check outputs mid-cycle, advance the model.
  task automatic cyc(input bit req, input int dest, input bit den, input int d, input int src,
                     input int rd, input bit ext, input bit vld, input bit kill);
    bit ei, en_e, dok;
    int src_e, dest_e, mk;
    i_req = req; i_dest = REGW'(dest); i_dest_en = den; i_delay = 4'(d);
    i_src = SRCW'(src); i_rd_mask = NREG'(rd); i_ext_conflict = ext;
    i_issue_vld = vld; i_kill = kill;
    #3;
    ei = m_issue(req, dest, den, d, rd, ext, kill);
    mk = m_mask();
    en_e = 1'b0; src_e = 0; dest_e = 0;
    foreach (pq[j]) if (pq[j].due == now) begin
      en_e = 1'b1; src_e = pq[j].src; dest_e = pq[j].dest;
    end
    chk("issue", 32'(o_issue), 32'(ei));
    chk("result_en", 32'(o_result_en), 32'(en_e));
    chk("result_src", 32'(o_result_src), 32'(src_e));
    chk("result_dest", 32'(o_result_dest), 32'(dest_e));
    chk("res_mask", 32'(o_res_mask), 32'(mk));
    chk("r0_busy", 32'(o_r0_busy), 32'(mk & 1));
    chk("err", 32'(o_err), 32'(err_m));
    dok = (d >= 1) && (d <= MAXLAT);
    if (rst) begin
      pq.delete();
      err_m = 1'b0;
    end else begin
      if ((vld && req && !ei && !kill) || (vld && req && den && !dok)) err_m = 1'b1;
      if (kill) pq.delete();
      else if (req && den && vld && ei) pq.push_back('{now + d, src, dest});
    end
    @(posedge clk);
    #1;
    now++;
    for (int j = pq.size() - 1; j >= 0; j--) if (pq[j].due < now) pq.delete(j);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    b_rst = 1'b1; b_req = 0; b_dest = 0; b_dest_en = 0; b_delay = 0; b_src = 0;
    b_rd_mask = 0; b_vld = 0;
    i_req = 0; i_dest = 0; i_dest_en = 0; i_delay = 0; i_src = 0; i_rd_mask = 0;
    i_ext_conflict = 0; i_issue_vld = 0; i_kill = 0;
    @(posedge clk); #1;
    idle(1);
    rst = 1'b0;
    idle(2);

    // Single issue: dest 5, delay 3, src 2.
    cyc(1, 5, 1, 3, 2, 0, 0, 1, 0);
    chk("single_mask1", 32'(o_res_mask), 32'h20);
    idle(2);
    chk("single_en", 32'(o_result_en), 32'd1);
    chk("single_dest", 32'(o_result_dest), 32'd5);
    idle(1);
    chk("single_done", 32'(o_res_mask), 32'h0);
    idle(1);

    // RAW hazard: reader of r2 blocked while r2 pending.
    cyc(1, 2, 1, 4, 7, 0, 0, 1, 0);
    for (int j = 0; j < 5; j++) cyc(1, 6, 1, 2, 1, 8'h04, 0, 0, 0);
    cyc(1, 6, 1, 2, 1, 8'h04, 0, 1, 0);
    idle(3);

    // Write-path conflict then a non-conflicting follow-up.
    cyc(1, 1, 1, 2, 3, 0, 0, 1, 0);
    cyc(1, 3, 1, 1, 4, 0, 0, 0, 0);
    idle(3);
    cyc(1, 1, 1, 2, 3, 0, 0, 1, 0);
    cyc(1, 3, 1, 3, 4, 0, 0, 1, 0);
    idle(4);

    // No-destination commit loads nothing.
    cyc(1, 4, 0, 0, 9, 0, 0, 1, 0);
    chk("nodest_mask", 32'(o_res_mask), 32'h0);
    idle(1);

    // Kill with three pending and a simultaneous commit.
    cyc(1, 3, 1, 9, 5, 0, 0, 1, 0);
    cyc(1, 4, 1, 5, 6, 0, 0, 1, 0);
    cyc(1, 6, 1, 2, 8, 0, 0, 1, 0);
    cyc(1, 7, 1, 4, 2, 0, 0, 1, 1);
    chk("kill_mask", 32'(o_res_mask), 32'h0);
    chk("kill_err", 32'(o_err), 32'd0);
    idle(10);

    // Max latency: back-to-back d=14, then an illegal d=15 forced.
    cyc(1, 0, 1, 14, 1, 0, 0, 1, 0);
    cyc(1, 1, 1, 14, 2, 0, 0, 1, 0);
    cyc(1, 7, 1, 15, 3, 0, 0, 1, 0);
    chk("d15_err", 32'(o_err), 32'd1);
    idle(15);

    // Reset with pending results.
    cyc(1, 2, 1, 6, 5, 0, 0, 1, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_mask", 32'(o_res_mask), 32'h0);
    chk("rst_err", 32'(o_err), 32'd0);
    idle(8);

    // Random phase.
    for (int n = 0; n < 400; n++) begin
      bit req, den, ext, vld, kill;
      int dest, d, src, rd;
      req  = ($urandom_range(0, 3) != 0);
      dest = $urandom_range(0, NREG - 1);
      den  = ($urandom_range(0, 4) != 0);
      d    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, MAXLAT);
      src  = $urandom_range(0, 15);
      rd   = int'($urandom & $urandom & $urandom) & 8'hff;
      ext  = ($urandom_range(0, 9) == 0);
      kill = ($urandom_range(0, 39) == 0);
      vld  = m_issue(req, dest, den, d, rd, ext, kill) ? ($urandom_range(0, 9) < 7)
                                                      : ($urandom_range(0, 29) == 0);
      rst  = ($urandom_range(0, 59) == 0);
      cyc(req, dest, den, d, src, rd, ext, vld, kill);
    end
    rst = 1'b0;
    idle(16);

    // Wider instance: dest 15, delay 3.
    @(posedge clk); #1;
    b_rst = 1'b0;
    #3;
    chk("w16_rst_mask", 32'(b_mask), 32'h0);
    chk("w16_rst_err", 32'(b_err), 32'd0);
    b_req = 1; b_dest = 4'd15; b_dest_en = 1; b_delay = 4'd3; b_src = 5'h1b; b_vld = 1;
    #1;
    chk("w16_issue", 32'(b_issue), 32'd1);
    @(posedge clk); #1;
    b_req = 0; b_vld = 0; b_dest_en = 0;
    chk("w16_mask1", 32'(b_mask), 32'h8000);
    chk("w16_en1", 32'(b_ren), 32'd0);
    @(posedge clk); #1;
    chk("w16_mask2", 32'(b_mask), 32'h8000);
    @(posedge clk); #1;
    chk("w16_en3", 32'(b_ren), 32'd1);
    chk("w16_dest3", 32'(b_rdest), 32'd15);
    chk("w16_src3", 32'(b_rsrc), 32'h1b);
    chk("w16_r0", 32'(b_r0), 32'd0);
    @(posedge clk); #1;
    chk("w16_en4", 32'(b_ren), 32'd0);
    chk("w16_mask4", 32'(b_mask), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
